decodificador_bcd_display: RTL and testbench
============================================

Name: decodificador_bcd_display

Overview:
Inverse-direction companion to the keypad priority encoder. It accepts BCD digits, one per load strobe, into a shift register of NUM_DIGITS digits. It time-multiplexes those digits onto a common-anode 7-segment display and also re-expands the newest digit to a 10-bit one-hot code. It sits between the encoder output and the board display.

Parameters:
NUM_DIGITS, 4, number of display digits held and scanned (2..8)
REFRESH_DIV, 50000, clk cycles each digit stays lit (>=2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
bcd_in  input  4  BCD digit to enter
load  input  1  single-cycle strobe: shift bcd_in in as newest digit
clear  input  1  synchronous: blank all digits
enablen  input  1  active-low enable; 1 = display dark, load ignored
seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low, registered
an_n  output  NUM_DIGITS  digit select, active-low one-hot, registered
onehot  output  10  bit k set when newest digit = k; 0 when blank
digit_count  output  clog2(NUM_DIGITS+1)  valid digits held, saturating

Behaviour:
- Reset (async): all digit slots = BLANK (4'hF); prescaler = 0; scan index = 0; seg_n = 7'h7F; an_n = all ones; onehot = 0; digit_count = 0.
- Digit store, slot 0 = newest = rightmost:
  - clear=1: all slots BLANK, digit_count = 0. Clear has priority over a simultaneous load.
  - load=1 and enablen=0: slot[i] <= slot[i-1]; slot[0] <= bcd_in. If bcd_in > 9, BLANK is stored instead.
  - digit_count increments on valid loads only (bcd_in <= 9) and saturates at NUM_DIGITS. A BLANK load does not increment it.
  - The oldest digit is discarded on overflow.
  - load with enablen=1: ignored.
- Prescaler: counts 0..REFRESH_DIV-1 continuously, regardless of enablen.
  - At the terminal count it wraps to 0 and the scan index advances.
  - Index wraps from NUM_DIGITS-1 to 0.
- Outputs:
  - an_n and seg_n are registered together, one clk after the index or digit contents change.
  - an_n = ~(1 << index). seg_n = decode(slot[index]).
  - enablen=1: an_n = all ones and seg_n = 7'h7F on the next clk.
- Segment decode, active-low gfedcba:
  0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. BLANK and 10..15 = 1111111.
- onehot: registered. Equals 1<<slot[0] when slot[0] <= 9, else 0. It updates one clk after the load or clear, and is independent of enablen.
- Reset asserted mid-scan or mid-load: immediate return to reset values; no partial shift is retained.

Optional Feature:
ZERO_SUPPRESS_EN
- Defined: a slot holding 0 is displayed blank when every older slot (higher index) is BLANK or a suppressed 0. Slot 0 is never suppressed, so value 0 shows a single "0". Only the display is affected; storage, onehot and digit_count are unchanged.
- Undefined: every stored 0 is displayed as "0".

Decomposition:
- Package decodificador_pkg holds:
  - BLANK = 4'hF;
  - SEG_BLANK = 7'h7F;
  - the ten segment constants SEG_0..SEG_9;
  - a digit typedef (4-bit logic).
- One sub-module, bcd_para_7seg: combinational 4-bit to 7-bit active-low decoder, instantiated once on the scanned slot.
- The prescaler, scan index, digit store and one-hot output stay in the top module.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4):
- Reset released, no loads -> an_n steps 1110,1101,1011,0111 every 4 clks; seg_n stays 7'h7F; onehot=0; digit_count=0.
- load 1,2,3,4 -> digit_count=4. When an_n=1110, seg_n=0011001 ("4"); when an_n=0111, seg_n=1111001 ("1"). After the load of 4, onehot=10'b0000010000.
- Fifth load of 9 -> the "1" is discarded; slots = 2,3,4,9; digit_count stays 4; onehot bit9 set.
- load bcd_in=4'hC -> slot0 BLANK, onehot=0, digit_count unchanged; that digit shows 1111111.
- load and clear in the same clk -> all slots BLANK, digit_count=0.
- enablen=1 while load pulses -> contents unchanged, an_n=1111 next clk.
- With ZERO_SUPPRESS_EN, load 0,0,5 -> digits 3..1 blank, digit 0 shows "5". Then load 0 -> "50", i.e. slot1=5 and slot0=0 both shown.
- Reset asserted asynchronously mid-scan -> all outputs return to reset values in the same cycle, without waiting for a clk edge.

Source files
------------

// File: rtl/decodificador_pkg.sv
// Shared definitions for the BCD-to-display decoder.
// Holds the BLANK digit code, the active-low segment patterns ({g,f,e,d,c,b,a})
// and the digit type used by the top module and by the segment decoder.
package decodificador_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t     BLANK     = 4'hF;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/decodificador_bcd_display_bcd_para_7seg.sv
// bcd_para_7seg: combinational BCD digit to common-anode 7-segment decoder.
// Ports:
//   digit_i  - 4-bit digit; 0..9 decode to numerals, 10..15 (incl. BLANK) go dark
//   seg_n_o  - active-low segments {g,f,e,d,c,b,a}
module bcd_para_7seg
    import decodificador_pkg::*;
(
    input  digit_t     digit_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = SEG_BLANK;
        unique case (digit_i)
            4'd0:    seg_n_o = SEG_0;
            4'd1:    seg_n_o = SEG_1;
            4'd2:    seg_n_o = SEG_2;
            4'd3:    seg_n_o = SEG_3;
            4'd4:    seg_n_o = SEG_4;
            4'd5:    seg_n_o = SEG_5;
            4'd6:    seg_n_o = SEG_6;
            4'd7:    seg_n_o = SEG_7;
            4'd8:    seg_n_o = SEG_8;
            4'd9:    seg_n_o = SEG_9;
            default: seg_n_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/decodificador_bcd_display.sv
// decodificador_bcd_display: BCD digit store with multiplexed 7-segment scan.
// Digits enter a NUM_DIGITS-deep shift register (slot 0 = newest = rightmost),
// are scanned onto a common-anode display and the newest digit is re-expanded
// to a 10-bit one-hot code.
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous active-high reset
//   bcd_in       - digit to enter; values above 9 are stored as BLANK
//   load         - single-cycle strobe shifting bcd_in in (ignored when enablen=1)
//   clear        - synchronous blank of all slots, wins over load
//   enablen      - active-low enable; 1 darkens the display and blocks loads
//   seg_n        - registered active-low segments {g,f,e,d,c,b,a}
//   an_n         - registered active-low one-hot digit select
//   onehot       - registered one-hot of the newest digit, 0 when it is BLANK
//   digit_count  - number of valid digits held, saturating at NUM_DIGITS
// Build option: define ZERO_SUPPRESS_EN to blank leading zeros on the display.
module decodificador_bcd_display
    import decodificador_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [3:0]                        bcd_in,
    input  logic                              load,
    input  logic                              clear,
    input  logic                              enablen,
    output logic [6:0]                        seg_n,
    output logic [NUM_DIGITS-1:0]             an_n,
    output logic [9:0]                        onehot,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count
);

    localparam int unsigned CntW = $clog2(NUM_DIGITS + 1);
    localparam int unsigned IdxW = $clog2(NUM_DIGITS);
    localparam int unsigned PreW = $clog2(REFRESH_DIV);

    digit_t                slot_q [NUM_DIGITS];
    digit_t                slot_d [NUM_DIGITS];
    logic [CntW-1:0]       count_q, count_d;
    logic [PreW-1:0]       pre_q, pre_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [6:0]            seg_n_q, seg_n_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    logic [9:0]            onehot_q, onehot_d;

    digit_t     scan_digit;
    digit_t     shown_digit;
    logic       suppress;
    logic [6:0] scan_seg_n;
    logic       bcd_valid;

    assign bcd_valid = (bcd_in <= 4'd9);

    // Digit store and valid-digit counter.
    always_comb begin
        slot_d  = slot_q;
        count_d = count_q;
        if (clear) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                slot_d[i] = BLANK;
            end
            count_d = '0;
        end else if (load && !enablen) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                slot_d[i] = slot_q[i-1];
            end
            slot_d[0] = bcd_valid ? digit_t'(bcd_in) : BLANK;
            if (bcd_valid && (count_q < CntW'(NUM_DIGITS))) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Free-running prescaler; the scan index steps on its terminal count.
    always_comb begin
        pre_d = pre_q + 1'b1;
        idx_d = idx_q;
        if (pre_q == PreW'(REFRESH_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    assign scan_digit = slot_q[idx_q];

`ifdef ZERO_SUPPRESS_EN
    // A zero is a leading zero when every older slot is BLANK or zero; slot 0
    // always shows so a lone 0 still reads "0".
    always_comb begin
        suppress = (idx_q != '0) && (scan_digit == 4'd0);
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((j > int'(idx_q)) && (slot_q[j] != 4'd0) && (slot_q[j] != BLANK)) begin
                suppress = 1'b0;
            end
        end
    end
`else
    always_comb begin
        suppress = 1'b0;
    end
`endif

    assign shown_digit = suppress ? BLANK : scan_digit;

    bcd_para_7seg u_bcd_para_7seg (
        .digit_i (shown_digit),
        .seg_n_o (scan_seg_n)
    );

    always_comb begin
        if (enablen) begin
            an_n_d  = '1;
            seg_n_d = SEG_BLANK;
        end else begin
            an_n_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_n_d = scan_seg_n;
        end
        // Follows the newest slot as it is written, independent of enablen.
        onehot_d = (slot_d[0] <= 4'd9) ? (10'd1 << slot_d[0]) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                slot_q[i] <= BLANK;
            end
            count_q  <= '0;
            pre_q    <= '0;
            idx_q    <= '0;
            seg_n_q  <= SEG_BLANK;
            an_n_q   <= '1;
            onehot_q <= '0;
        end else begin
            slot_q   <= slot_d;
            count_q  <= count_d;
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            seg_n_q  <= seg_n_d;
            an_n_q   <= an_n_d;
            onehot_q <= onehot_d;
        end
    end

    assign seg_n       = seg_n_q;
    assign an_n        = an_n_q;
    assign onehot      = onehot_q;
    assign digit_count = count_q;

endmodule

// File: tb/tb_decodificador_bcd_display.sv
// Testbench for decodificador_bcd_display (NUM_DIGITS=4, REFRESH_DIV=4).
// Directed sequences followed by randomized load/clear/enable traffic, checked
// every cycle against a digit-list reference model of the display.
module tb_decodificador_bcd_display;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] bcd_in;
    logic       load;
    logic       clear;
    logic       enablen;
    logic [6:0] seg_n;
    logic [N-1:0] an_n;
    logic [9:0] onehot;
    logic [2:0] digit_count;

    always #5 clk = ~clk;

    decodificador_bcd_display #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bcd_in      (bcd_in),
        .load        (load),
        .clear       (clear),
        .enablen     (enablen),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .onehot      (onehot),
        .digit_count (digit_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: digits listed newest first, plus scan position.
    logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};
    int         m_dig [N];
    int         m_count;
    int         m_tick;
    int         m_pos;
    logic [N-1:0] e_an;
    logic [6:0] e_seg;
    logic [9:0] e_oh;

    function automatic logic [6:0] shown_seg(input int pos);
        int v;
        v = m_dig[pos];
`ifdef ZERO_SUPPRESS_EN
        if (pos > 0 && v == 0) begin
            bit lead;
            lead = 1'b1;
            for (int j = pos + 1; j < N; j++)
                if (m_dig[j] != 0 && m_dig[j] != 15) lead = 1'b0;
            if (lead) v = 15;
        end
`endif
        return (v <= 9) ? segtab[v] : 7'h7F;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_dig[i] = 15;
        m_count = 0;
        m_tick  = 0;
        m_pos   = 0;
        e_an    = '1;
        e_seg   = 7'h7F;
        e_oh    = '0;
    endtask

    // One rising edge: display outputs reflect the state before the edge.
    task automatic model_step();
        int v;
        if (enablen) begin
            e_an  = '1;
            e_seg = 7'h7F;
        end else begin
            e_an  = '1;
            e_an[m_pos] = 1'b0;
            e_seg = shown_seg(m_pos);
        end
        if (clear) begin
            for (int i = 0; i < N; i++) m_dig[i] = 15;
            m_count = 0;
        end else if (load && !enablen) begin
            v = int'(bcd_in);
            for (int i = N - 1; i > 0; i--) m_dig[i] = m_dig[i-1];
            m_dig[0] = (v <= 9) ? v : 15;
            if (v <= 9 && m_count < N) m_count++;
        end
        e_oh = (m_dig[0] <= 9) ? (10'd1 << m_dig[0]) : 10'd0;
        m_tick++;
        if (m_tick == DIV) begin
            m_tick = 0;
            m_pos  = (m_pos + 1) % N;
        end
    endtask

    task automatic compare_all();
        check("an_n", 32'(an_n), 32'(e_an));
        check("seg_n", 32'(seg_n), 32'(e_seg));
        check("onehot", 32'(onehot), 32'(e_oh));
        check("digit_count", 32'(digit_count), 32'(m_count));
    endtask

    // Called at a falling edge: apply inputs, take one rising edge, check.
    task automatic step(input logic ld, input logic [3:0] bcd, input logic clr,
                        input logic en);
        load    = ld;
        bcd_in  = bcd;
        clear   = clr;
        enablen = en;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic       r_ld, r_clr, r_en;
        logic [3:0] r_bcd;

        reset   = 1'b1;
        load    = 1'b0;
        bcd_in  = 4'd0;
        clear   = 1'b0;
        enablen = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        reset = 1'b0;

        // Empty scan.
        idle(17);

        // Fill, overflow, invalid digit.
        step(1'b1, 4'd1, 1'b0, 1'b0);
        step(1'b1, 4'd2, 1'b0, 1'b0);
        step(1'b1, 4'd3, 1'b0, 1'b0);
        step(1'b1, 4'd4, 1'b0, 1'b0);
        idle(16);
        step(1'b1, 4'd9, 1'b0, 1'b0);
        idle(16);
        step(1'b1, 4'hC, 1'b0, 1'b0);
        idle(16);

        // Clear beats load; disabled loads are dropped.
        step(1'b1, 4'd7, 1'b0, 1'b0);
        step(1'b1, 4'd5, 1'b1, 1'b0);
        step(1'b1, 4'd6, 1'b0, 1'b0);
        step(1'b1, 4'd8, 1'b0, 1'b1);
        step(1'b1, 4'd3, 1'b0, 1'b1);
        idle(8);

        // Leading-zero pattern.
        step(1'b1, 4'd0, 1'b1, 1'b0);
        step(1'b1, 4'd0, 1'b0, 1'b0);
        step(1'b1, 4'd0, 1'b0, 1'b0);
        step(1'b1, 4'd5, 1'b0, 1'b0);
        idle(16);
        step(1'b1, 4'd0, 1'b0, 1'b0);
        idle(16);

        // Asynchronous reset between clock edges.
        #2 reset = 1'b1;
        #1;
        check("async_an_n", 32'(an_n), 32'hF);
        check("async_seg_n", 32'(seg_n), 32'h7F);
        check("async_onehot", 32'(onehot), 32'h0);
        check("async_digit_count", 32'(digit_count), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        idle(5);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            r_ld  = ($urandom_range(0, 2) == 0);
            r_bcd = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15))
                  : ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
            r_clr = ($urandom_range(0, 40) == 0);
            r_en  = ($urandom_range(0, 12) == 0);
            step(r_ld, r_bcd, r_clr, r_en);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
